// File: rtl/even_parity_uart_tx.sv
// even_parity_uart_tx
// Serial transmitter: start bit, 8 data bits LSB first, even parity bit, stop.
// The parity bit is derived from the latched byte, so every frame satisfies
// XOR(data bits, parity bit) == 0.
// Optional feature: define EVEN_PARITY_TX_STOP2_EN for two stop bits.
module even_parity_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // Bit-timer is wide enough for 0..CLKS_PER_BIT-1, never narrower than 1.
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t         state;
    logic [7:0]     shift_reg;
    logic           par;
    logic [TW-1:0]  timer;
    logic [2:0]     index;

    logic timer_last;
    logic last_stop;

    assign timer_last = (timer == T_LAST);

`ifdef EVEN_PARITY_TX_STOP2_EN
    // Two stop bits: the index counter is reused to count them (0, 1).
    assign last_stop = (index == 3'd1);
`else
    // One stop bit: the first stop bit is also the last.
    assign last_stop = 1'b1;
`endif

    // Frame sequencer: state, datapath and all outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register, datapath included, has a defined reset value so
        // an abandoned frame leaves nothing behind; there is no memory array here.
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            par       <= 1'b0;
            timer     <= '0;
            index     <= '0;
            tx        <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side sees the pre-edge value (e.g. shift_reg[1] below).
            done <= 1'b0;

            if (state != IDLE) begin
                timer <= timer_last ? '0 : timer + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        shift_reg <= data_in;
                        par       <= ^data_in;
                        timer     <= '0;
                        index     <= '0;
                        state     <= START;
                        tx        <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (timer_last) begin
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end
                end

                DATA: begin
                    if (timer_last) begin
                        shift_reg <= shift_reg >> 1;
                        // Index wraps 7 -> 0, leaving it cleared for STOP.
                        index     <= index + 3'd1;
                        if (index == 3'd7) begin
                            state <= PARITY;
                            tx    <= par;
                        end else begin
                            tx    <= shift_reg[1];
                        end
                    end
                end

                PARITY: begin
                    if (timer_last) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end

                STOP: begin
                    // done is registered, so it is raised one cycle early to
                    // land exactly on the final cycle of the last stop bit.
                    if (last_stop && timer == T_PRE) begin
                        done <= 1'b1;
                    end
                    if (timer_last) begin
                        if (last_stop) begin
                            state <= IDLE;
                            index <= '0;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_even_parity_uart_tx.sv
// Self-checking bench for even_parity_uart_tx with CLKS_PER_BIT = 4.
// Expected frames come from a bit-level frame model (start, data LSB first,
// parity from the count of ones, stop bits); tx is sampled at mid-bit.
module tb_even_parity_uart_tx;

    localparam int C = 4;
`ifdef EVEN_PARITY_TX_STOP2_EN
    localparam int SB = 2;
`else
    localparam int SB = 1;
`endif
    localparam int FL = (10 + SB) * C;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    even_parity_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference frame: bit k of the serial frame for byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9) return logic'($countones(b) % 2);
        return 1'b1;
    endfunction

    // Wait (bounded) for ready, then hand over one byte at the next edge.
    task automatic accept(input logic [7:0] b);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", ready, 1'b1);
        data_in = b;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        data_in = 8'($urandom);
    endtask

    // Send one byte and check every cycle of its frame plus the idle cycle.
    // hold=1 keeps valid high (back-to-back); hold=0 toggles valid randomly.
    task automatic run_frame(input logic [7:0] b, input bit hold);
        logic [9:0] rx;
        int k;
        rx = '0;
        accept(b);
        for (int c = 1; c <= FL; c++) begin
            @(negedge clk);
            k = (c - 1) / C;
            if ((c - 1) % C == C / 2) begin
                check($sformatf("tx_%02h_bit%0d", b, k), tx, frame_bit(b, k));
                if (k < 10) rx[k] = tx;
            end
            check($sformatf("done_%02h_c%0d", b, c), done, (c == FL));
            check($sformatf("busy_%02h_c%0d", b, c), busy, 1'b1);
            check($sformatf("ready_%02h_c%0d", b, c), ready, 1'b0);
            data_in = 8'($urandom);
            if (!hold) valid = (c == FL) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        // Reference receiver: recover byte and verify even parity.
        check($sformatf("rx_data_%02h", b), rx[8:1], b);
        check($sformatf("rx_parity_%02h", b), ^rx[9:1], 1'b0);
        @(negedge clk);
        check($sformatf("idle_tx_%02h", b), tx, 1'b1);
        check($sformatf("idle_ready_%02h", b), ready, 1'b1);
        check($sformatf("idle_busy_%02h", b), busy, 1'b0);
        check($sformatf("idle_done_%02h", b), done, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        #2;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1'b1);
            check("idle_ready", ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
        end

        // Directed bytes: even weight, then odd weight.
        run_frame(8'hA5, 1'b0);
        run_frame(8'h07, 1'b0);

        // Back-to-back with valid held high: exactly one idle cycle between.
        run_frame(8'h00, 1'b1);
        run_frame(8'hFF, 1'b1);
        valid = 1'b0;

        // Random bytes with random valid behaviour.
        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)));
            valid = 1'b0;
        end

        // Reset during DATA bit 3 of 0x3C.
        @(negedge clk);
        accept(8'h3C);
        valid = 1'b0;
        for (int c = 1; c <= 18; c++) @(negedge clk);
        check("mid_busy_pre", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_done", done, 1'b0);
            check("rst_hold_tx", tx, 1'b1);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 1'b0);
            check("post_rst_tx", tx, 1'b1);
        end
        run_frame(8'h81, 1'b0);
        valid = 1'b0;

        // The configured stop length in isolation, byte 0x55.
        run_frame(8'h55, 1'b0);
        valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
